// File: rtl/spi_shift_engine.sv
// SPI master shift engine: 8-bit transfers, all four CPOL/CPHA modes, programmable SCLK half-period.
// Define SPI_SHIFT_LSB_FIRST_EN for LSB-first bit order; MSB-first otherwise.
module spi_shift_engine (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  din,
  input  logic [15:0] dvsr,
  input  logic        start,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        miso,
  output logic [7:0]  dout,
  output logic        sclk,
  output logic        mosi,
  output logic        spi_done_tick,
  output logic        ready
);

  typedef enum logic [1:0] {IDLE, CPHA_DLY, P0, P1} state_t;

  state_t      state_reg, state_next;
  logic [15:0] c_reg, c_next;
  logic [2:0]  n_reg, n_next;
  logic [7:0]  tx_reg, tx_next;
  logic [7:0]  rx_reg, rx_next;
  logic [7:0]  dout_reg, dout_next;
  logic [15:0] dvsr_reg, dvsr_next;
  logic        cpol_reg, cpol_next;
  logic        cpha_reg, cpha_next;
  logic [7:0]  tx_shifted, rx_shifted;
  logic        last_half;
  logic        sclk_raw;

`ifdef SPI_SHIFT_LSB_FIRST_EN
  assign mosi       = tx_reg[0];
  assign tx_shifted = {1'b0, tx_reg[7:1]};
  assign rx_shifted = {miso, rx_reg[7:1]};
`else
  assign mosi       = tx_reg[7];
  assign tx_shifted = {tx_reg[6:0], 1'b0};
  assign rx_shifted = {rx_reg[6:0], miso};
`endif

  // c only ever counts up to the latched divisor and is cleared there, so it cannot wrap
  assign last_half = (c_reg == dvsr_reg);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      c_reg     <= '0;
      n_reg     <= '0;
      tx_reg    <= '0;
      rx_reg    <= '0;
      dout_reg  <= '0;
      dvsr_reg  <= '0;
      cpol_reg  <= 1'b0;
      cpha_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      c_reg     <= c_next;
      n_reg     <= n_next;
      tx_reg    <= tx_next;
      rx_reg    <= rx_next;
      dout_reg  <= dout_next;
      dvsr_reg  <= dvsr_next;
      cpol_reg  <= cpol_next;
      cpha_reg  <= cpha_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    c_next        = c_reg;
    n_next        = n_reg;
    tx_next       = tx_reg;
    rx_next       = rx_reg;
    dout_next     = dout_reg;
    dvsr_next     = dvsr_reg;
    cpol_next     = cpol_reg;
    cpha_next     = cpha_reg;
    spi_done_tick = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          tx_next    = din;
          dvsr_next  = dvsr;
          cpol_next  = cpol;
          cpha_next  = cpha;
          c_next     = '0;
          n_next     = '0;
          state_next = cpha ? CPHA_DLY : P0;
        end
      end
      CPHA_DLY: begin
        if (last_half) begin
          c_next     = '0;
          state_next = P0;
        end else begin
          c_next = c_reg + 16'd1;
        end
      end
      P0: begin
        if (last_half) begin
          rx_next    = rx_shifted;
          c_next     = '0;
          state_next = P1;
        end else begin
          c_next = c_reg + 16'd1;
        end
      end
      P1: begin
        if (last_half) begin
          c_next = '0;
          if (n_reg == 3'd7) begin
            // Done is a Mealy pulse in the final cycle so ready rises right after it
            spi_done_tick = 1'b1;
            dout_next     = rx_reg;
            state_next    = IDLE;
          end else begin
            tx_next    = tx_shifted;
            n_next     = n_reg + 3'd1;
            state_next = P0;
          end
        end else begin
          c_next = c_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sclk_raw = cpha_reg ? (state_reg == P0) : (state_reg == P1);
  assign sclk     = (state_reg == IDLE) ? cpol : (sclk_raw ^ cpol_reg);
  assign ready    = (state_reg == IDLE);
  assign dout     = dout_reg;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: timing, data, mode, abort and ignored-start cases.
// Honours SPI_SHIFT_LSB_FIRST_EN for the one bit-order dependent expectation.
module tb_spi_shift_engine;

  logic        clk;
  logic        reset_n;
  logic [7:0]  din;
  logic [15:0] dvsr;
  logic        start;
  logic        cpol;
  logic        cpha;
  logic        miso;
  logic [7:0]  dout;
  logic        sclk;
  logic        mosi;
  logic        spi_done_tick;
  logic        ready;

  int          n_checks = 0;
  int          n_errors = 0;
  int          rise_cnt = 0;
  int          fall_cnt = 0;
  int          fall_base = 0;
  int          miso_sel = 0;
  logic [7:0]  slave_byte = 8'h00;
  logic [7:0]  mosi_hist = 8'h00;
  logic [2:0]  slave_idx;

  spi_shift_engine dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .din           (din),
    .dvsr          (dvsr),
    .start         (start),
    .cpol          (cpol),
    .cpha          (cpha),
    .miso          (miso),
    .dout          (dout),
    .sclk          (sclk),
    .mosi          (mosi),
    .spi_done_tick (spi_done_tick),
    .ready         (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge sclk) begin
    rise_cnt  <= rise_cnt + 1;
    mosi_hist <= {mosi_hist[6:0], mosi};
  end
  always @(negedge sclk) fall_cnt <= fall_cnt + 1;

  // Slave model: MSB-first, next bit presented on each falling SCLK edge
  assign slave_idx = 3'(fall_cnt - fall_base);
  always_comb begin
    case (miso_sel)
      0:       miso = mosi;
      1:       miso = 1'b1;
      default: miso = slave_byte[3'd7 - slave_idx];
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] d, input logic [15:0] dv,
                          input logic cp, input logic ph, input int msel, input logic [7:0] sbyte,
                          input logic [7:0] exp_dout, input int exp_cycles, input int inject_at,
                          input int abort_at, input logic [7:0] exp_hist);
    int   limit;
    int   done_at;
    int   done_cnt;
    int   early_ready;
    int   rise_base;
    logic ready_at_done;
    logic ready_after;
    limit = (abort_at > 0) ? 40 : exp_cycles + 4;
    done_at = 0; done_cnt = 0; early_ready = 0;
    ready_at_done = 1'b1; ready_after = 1'b0;
    @(negedge clk);
    din = d; dvsr = dv; cpol = cp; cpha = ph; miso_sel = msel; slave_byte = sbyte;
    @(negedge clk);
    check({tag, "_idle_sclk"}, 32'(sclk), 32'(cp));
    check({tag, "_idle_ready"}, 32'(ready), 32'd1);
    rise_base = rise_cnt;
    fall_base = fall_cnt;
    start = 1'b1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (inject_at > 0 && k == inject_at) begin
        start = 1'b1; din = 8'hFF; dvsr = 16'd0;
      end
      if (inject_at > 0 && k == inject_at + 1) start = 1'b0;
      #1;
      if (spi_done_tick) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = k;
          ready_at_done = ready;
        end
      end
      if (done_at > 0 && k == done_at + 1) ready_after = ready;
      if (abort_at == 0 && k < exp_cycles && ready) early_ready++;
      if (abort_at > 0 && k == abort_at) reset_n = 1'b0;
      if (abort_at > 0 && k == abort_at + 1) begin
        check({tag, "_abort_ready"}, 32'(ready), 32'd1);
        check({tag, "_abort_dout"}, 32'(dout), 32'h00);
        check({tag, "_abort_mosi"}, 32'(mosi), 32'd0);
        reset_n = 1'b1;
      end
    end
    if (abort_at > 0) begin
      check({tag, "_abort_no_done"}, 32'(done_cnt), 32'd0);
      $display("xfer %s: aborted at cycle %0d, dout=%02h", tag, abort_at, dout);
    end else begin
      check({tag, "_done_at"}, 32'(done_at), 32'(exp_cycles));
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_ready_at_done"}, 32'(ready_at_done), 32'd0);
      check({tag, "_ready_after"}, 32'(ready_after), 32'd1);
      check({tag, "_busy_ready"}, 32'(early_ready), 32'd0);
      check({tag, "_dout"}, 32'(dout), 32'(exp_dout));
      check({tag, "_sclk_rises"}, 32'(rise_cnt - rise_base), 32'd8);
      check({tag, "_mosi_seq"}, 32'(mosi_hist), 32'(exp_hist));
      $display("xfer %s: din=%02h dvsr=%0d mode=%0d%0d done_at=%0d dout=%02h", tag, d, dv, cp, ph,
               done_at, dout);
    end
  endtask

  initial begin
    logic [7:0] lsb_hist;
`ifdef SPI_SHIFT_LSB_FIRST_EN
    lsb_hist = 8'h80;
`else
    lsb_hist = 8'h01;
`endif
    reset_n = 1'b0; start = 1'b0; din = 8'h00; dvsr = 16'd0; cpol = 1'b0; cpha = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(spi_done_tick), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_sclk_lo", 32'(sclk), 32'd0);
    cpol = 1'b1;
    #1;
    check("rst_sclk_hi", 32'(sclk), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    $display("reset: ready=%0d dout=%02h", ready, dout);

    run_xfer("mode0", 8'hA5, 16'd1, 1'b0, 1'b0, 0, 8'h00, 8'hA5, 32, 0, 0, 8'hA5);
    din = 8'h11;
    repeat (5) @(negedge clk);
    check("dout_hold", 32'(dout), 32'hA5);
    run_xfer("mode3", 8'h3C, 16'd3, 1'b1, 1'b1, 1, 8'h00, 8'hFF, 68, 0, 0, 8'h3C);
    run_xfer("dvsr0", 8'h81, 16'd0, 1'b0, 1'b0, 2, 8'h5A, 8'h5A, 16, 0, 0, 8'h81);
    run_xfer("restart", 8'hA5, 16'd1, 1'b0, 1'b0, 0, 8'h00, 8'hA5, 32, 5, 0, 8'hA5);
    run_xfer("abort", 8'h3C, 16'd1, 1'b0, 1'b0, 0, 8'h00, 8'h00, 0, 0, 10, 8'h00);
    run_xfer("after_abort", 8'h66, 16'd2, 1'b0, 1'b1, 0, 8'h00, 8'h66, 51, 0, 0, 8'h66);
    run_xfer("bit_order", 8'h01, 16'd1, 1'b0, 1'b0, 0, 8'h00, 8'h01, 32, 0, 0, lsb_hist);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
